// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS core.
// Holds the fetch FSM encoding, PC load selects and PC defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WRITE = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with hold / increment / load selection.
// pc_plus4 is the combinational successor address, wrapping modulo 2^32.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  pc_sel_t       sel,
    input  logic [31:0]   target,
    output logic [31:0]   pc,
    output logic [31:0]   pc_plus4
);

    assign pc_plus4 = pc + PC_INCR;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            unique case (sel)
                PC_INC:  pc <= pc_plus4;
                PC_LOAD: pc <= target;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: reads the word at pc over a req/ack handshake,
// strobes it into the IR, then advances pc or applies a pending redirect.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ir_we,
    output logic [31:0] ir_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_done,
    output logic        busy,
    output logic        misalign_err
);

    fetch_state_t state, state_nxt;
    pc_sel_t      pc_sel;
    logic [31:0]  pc_target;
    logic         pend_vld;
    logic [31:0]  pend_pc;
    logic         redirect_ok;
    logic         redirect_bad;

    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (pc_sel),
        .target   (pc_target),
        .pc       (pc),
        .pc_plus4 (pc_plus4)
    );

    assign mem_addr = pc;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_sel     = PC_HOLD;
        pc_target  = redirect_pc;
        mem_req    = 1'b0;
        ir_we      = 1'b0;
        fetch_done = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (redirect_ok) begin
                    pc_sel = PC_LOAD;
                end
                if (fetch_start) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                ir_we      = 1'b1;
                fetch_done = 1'b1;
                state_nxt  = ST_IDLE;
                // A redirect arriving in this very cycle is the latest one and wins.
                if (redirect_ok) begin
                    pc_sel = PC_LOAD;
                end else if (pend_vld) begin
                    pc_sel    = PC_LOAD;
                    pc_target = pend_pc;
                end else begin
                    pc_sel = PC_INC;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_pc  <= '0;
        end else if (state == ST_WRITE) begin
            pend_vld <= 1'b0;
        end else if (state == ST_REQ && redirect_ok) begin
            pend_vld <= 1'b1;
            pend_pc  <= redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ir_data <= '0;
        end else if (state == ST_REQ && mem_ack) begin
            ir_data <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_bad) begin
            misalign_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: reset, stalls, redirects, misalignment,
// PC wrap and mid-fetch reset, checked against hand-computed values.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_we;
    logic [31:0] ir_data;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        busy;
    logic        misalign_err;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int busy_cnt;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_start    (fetch_start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .ir_we          (ir_we),
        .ir_data        (ir_data),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .fetch_done     (fetch_done),
        .busy           (busy),
        .misalign_err   (misalign_err)
    );

    always @(negedge clk) begin
        if (ir_we === 1'b1) we_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; fetch_start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h4);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_we", {31'b0, ir_we}, 32'h0);
        chk("rst_done", {31'b0, fetch_done}, 32'h0);
        chk("rst_err", {31'b0, misalign_err}, 32'h0);
        chk("rst_ir", ir_data, 32'h0);

        // basic fetch, ack in the first request cycle
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h2008_0005;
        chk("f1_req", {31'b0, mem_req}, 32'h1);
        chk("f1_addr", mem_addr, 32'h0);
        chk("f1_we0", {31'b0, ir_we}, 32'h0);
        tick();
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        chk("f1_we", {31'b0, ir_we}, 32'h1);
        chk("f1_done", {31'b0, fetch_done}, 32'h1);
        chk("f1_ir", ir_data, 32'h2008_0005);
        chk("f1_req_drop", {31'b0, mem_req}, 32'h0);
        tick();
        chk("f1_pc", pc, 32'h4);
        chk("f1_idle", {31'b0, busy}, 32'h0);
        chk("f1_we_end", {31'b0, ir_we}, 32'h0);
        chk("f1_ir_hold", ir_data, 32'h2008_0005);

        // ack withheld for 5 cycles
        busy_cnt = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("st_req", {31'b0, mem_req}, 32'h1);
            chk("st_addr", mem_addr, 32'h4);
            chk("st_we0", {31'b0, ir_we}, 32'h0);
            if (busy === 1'b1) busy_cnt++;
            if (i == 5) begin
                mem_ack = 1'b1; mem_rdata = 32'h8C42_0010;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("st_we", {31'b0, ir_we}, 32'h1);
        chk("st_ir", ir_data, 32'h8C42_0010);
        if (busy === 1'b1) busy_cnt++;
        tick();
        chk("st_busy_end", {31'b0, busy}, 32'h0);
        chk("st_busy_cnt", busy_cnt, 32'd7);
        chk("st_pc", pc, 32'h8);

        // redirect during REQ
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        chk("rd1_addr_held", mem_addr, 32'h8);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rd1_pc", pc, 32'h0040_0100);

        // two redirects in one REQ: last wins
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        tick();
        redirect_pc = 32'h0040_0200;
        tick();
        redirect_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rd2_pc", pc, 32'h0040_0200);

        // redirect together with fetch_start in IDLE
        fetch_start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
        tick();
        fetch_start = 1'b0; redirect_valid = 1'b0;
        chk("rs_req", {31'b0, mem_req}, 32'h1);
        chk("rs_addr", mem_addr, 32'h0000_0080);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("rs_pc", pc, 32'h0000_0084);

        // misaligned redirect in IDLE
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0082;
        tick();
        redirect_valid = 1'b0;
        chk("ma_pc", pc, 32'h0000_0084);
        chk("ma_err", {31'b0, misalign_err}, 32'h1);
        tick(); tick();
        chk("ma_err_sticky", {31'b0, misalign_err}, 32'h1);

        // misaligned redirect in REQ leaves the +4 path intact
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0082;
        tick();
        redirect_valid = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("ma_req_pc", pc, 32'h0000_0088);

        // PC wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wr_pc", pc, 32'hFFFF_FFFC);
        chk("wr_pc4", pc_plus4, 32'h0);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        chk("wr_pc_after", pc, 32'h0);
        chk("wr_err_held", {31'b0, misalign_err}, 32'h1);

        // reset while in REQ
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        chk("mr_req", {31'b0, mem_req}, 32'h1);
        rst_n = 1'b0;
        mem_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b0;
        chk("mr_req_drop", {31'b0, mem_req}, 32'h0);
        chk("mr_busy", {31'b0, busy}, 32'h0);
        chk("mr_we", {31'b0, ir_we}, 32'h0);
        chk("mr_pc", pc, 32'h0);
        chk("mr_err", {31'b0, misalign_err}, 32'h0);
        chk("mr_ir", ir_data, 32'h0);
        tick();
        chk("mr_we_after", {31'b0, ir_we}, 32'h0);
        chk("mr_idle", {31'b0, busy}, 32'h0);
        chk("we_pulses", we_cnt, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
